// File: rtl/sobel_window_ctrl.sv
// Purpose  : streams a raster image through two line buffers and a 3x3 window, feeding the
//            combinational sobel_module and registering its 1-bit edge result per interior pixel.
// Latency  : edge bit valid one cycle after its triggering pixel (bottom-right of window) is accepted.
// Backpress: single output register, no skid: pix_ready = ~edge_valid | edge_ready.
// Ports    : pix_in/pix_valid/pix_sof/pix_ready  - pixel stream in, row-major, SOF marks (0,0)
//            threshold_in                        - sampled on the accepted SOF pixel
//            sob_p0..p8 (no p4), sob_threshold   - window taps / threshold to sobel_module
//            sob_result                          - combinational edge decision back from sobel_module
//            edge_out/edge_valid/edge_ready/edge_eol - edge stream out, eol on last interior column
//            busy, frame_done                    - frame in progress / one-cycle end-of-frame pulse
// Option   : SOBEL_EDGE_COUNT_EN adds a 16-bit saturating per-frame edge_count output.
module sobel_window_ctrl #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       pix_sof,
  output logic       pix_ready,
  input  logic [7:0] threshold_in,
  output logic [7:0] sob_p0,
  output logic [7:0] sob_p1,
  output logic [7:0] sob_p2,
  output logic [7:0] sob_p3,
  output logic [7:0] sob_p5,
  output logic [7:0] sob_p6,
  output logic [7:0] sob_p7,
  output logic [7:0] sob_p8,
  output logic [7:0] sob_threshold,
  input  logic       sob_result,
  output logic       edge_out,
  output logic       edge_valid,
  input  logic       edge_ready,
  output logic       edge_eol,
  output logic       busy,
`ifdef SOBEL_EDGE_COUNT_EN
  output logic [15:0] edge_count,
`endif
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  typedef struct packed {
    logic [7:0] top;
    logic [7:0] mid;
    logic [7:0] bot;
  } wcol_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col, col_eff;
  logic [RW-1:0] row, row_eff;
  logic          acc, frame_acc, last_pix, emit;
  logic [7:0]    lb0 [IMG_WIDTH];
  logic [7:0]    lb1 [IMG_WIDTH];
  wcol_t         win_new, win_mid, win_old;

  assign pix_ready = ~edge_valid | edge_ready;
  assign acc       = pix_valid & pix_ready;
  // Pixels outside a frame (IDLE, no SOF) are accepted but never touch counters or buffers.
  assign frame_acc = acc & (pix_sof | (state != IDLE));
  // An SOF pixel is position (0,0) regardless of where the counters currently stand.
  assign col_eff   = pix_sof ? '0 : col;
  assign row_eff   = pix_sof ? '0 : row;
  assign last_pix  = frame_acc & ~pix_sof & (row == ROW_LAST) & (col == COL_LAST);
  assign emit      = frame_acc & ~pix_sof & (row >= RW'(2)) & (col >= CW'(2));
  assign busy      = (state != IDLE);

  // Newest window column comes straight from the buffer reads and the incoming pixel.
  assign win_new.top = lb1[col_eff];
  assign win_new.mid = lb0[col_eff];
  assign win_new.bot = pix_in;

  assign sob_p0 = win_old.top;
  assign sob_p3 = win_old.mid;
  assign sob_p6 = win_old.bot;
  assign sob_p1 = win_mid.top;
  assign sob_p7 = win_mid.bot;
  assign sob_p2 = win_new.top;
  assign sob_p5 = win_new.mid;
  assign sob_p8 = win_new.bot;

  always_comb begin
    state_nxt = state;
    if (acc & pix_sof) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (frame_acc & (row == RW'(1)) & (col == COL_LAST)) state_nxt = RUN;
        RUN:     if (last_pix) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      col           <= '0;
      row           <= '0;
      win_mid       <= '0;
      win_old       <= '0;
      sob_threshold <= '0;
      edge_out      <= 1'b0;
      edge_valid    <= 1'b0;
      edge_eol      <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= last_pix;
      if (acc & pix_sof) sob_threshold <= threshold_in;
      if (frame_acc) begin
        win_old <= win_mid;
        win_mid <= win_new;
        if (col_eff == COL_LAST) begin
          col <= '0;
          row <= (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
        end else begin
          col <= col_eff + CW'(1);
          row <= row_eff;
        end
      end
      // A new result overrides the consume so the simultaneous ready+load case keeps valid high.
      if (emit) begin
        edge_out   <= sob_result;
        edge_eol   <= (col == COL_LAST);
        edge_valid <= 1'b1;
      end else if (edge_ready) begin
        edge_valid <= 1'b0;
      end
    end
  end

  // Line buffer storage carries no reset; a frame rewrites every column before reading it back.
  always_ff @(posedge clk) begin
    if (frame_acc) begin
      lb1[col_eff] <= lb0[col_eff];
      lb0[col_eff] <= pix_in;
    end
  end

`ifdef SOBEL_EDGE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_count <= '0;
    end else if (acc & pix_sof) begin
      edge_count <= '0;
    end else if (emit & sob_result & (edge_count != 16'hFFFF)) begin
      edge_count <= edge_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Streaming controller that sequences the combinational `sobel_module` across a raster image. It accepts 8-bit pixels in row-major order with a valid/ready handshake and keeps two line buffers plus a 3x3 window. For every interior pixel it drives the eight neighbour taps and the threshold into `sobel_module`, then registers the 1-bit edge result onto a valid/ready output stream. It sits between the pixel source (camera/frame reader) and the edge-map sink.

## Interface
- `IMG_WIDTH`, default 64: pixels per row; must be at least 3.
- `IMG_HEIGHT`, default 48: rows per frame; must be at least 3.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pix_in`  in  8  input pixel.
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_sof`  in  1  qualifies `pix_in` as pixel (0,0) of a frame.
- `pix_ready`  out  1  controller accepts the pixel this cycle.
- `threshold_in`  in  8  edge threshold; sampled on the accepted SOF pixel.
- `sob_p0`..`sob_p3`, `sob_p5`..`sob_p8`  out  8 each  window taps to `sobel_module`. p0..p2 are the top row (left to right), p3/p5 are the middle row left/right, and p6..p8 are the bottom row.
- `sob_threshold`  out  8  latched threshold to `sobel_module`.
- `sob_result`  in  1  combinational result from `sobel_module`.
- `edge_out`  out  1  registered edge bit.
- `edge_valid`  out  1  `edge_out` is valid.
- `edge_ready`  in  1  sink accepts `edge_out`.
- `edge_eol`  out  1  qualifies `edge_out` as the last interior column of a row.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Accept condition: `acc = pix_valid & pix_ready`.
- `pix_ready = ~edge_valid | edge_ready`. This is a single output register with no skid buffer.
- Counters: `col` counts 0..IMG_WIDTH-1 and `row` counts 0..IMG_HEIGHT-1. They advance on `acc`. `col` wraps to 0 and increments `row`.
- FSM states:
  - IDLE: waits for an SOF pixel. Non-SOF pixels are accepted and dropped.
  - FILL: rows 0 and 1 are arriving.
  - RUN: rows 2 and up.
- FSM transitions:
  - IDLE→FILL on an accepted SOF.
  - FILL→RUN when `row` becomes 2.
  - RUN→IDLE on accepting (IMG_HEIGHT-1, IMG_WIDTH-1), which also pulses `frame_done`.
- SOF during FILL or RUN restarts the frame: the counters go to (0,0) and the FSM to FILL. The line buffers are not cleared; their contents are simply overwritten. A pending `edge_valid` is still delivered.
- Line buffers: `lb0` holds the previous row and `lb1` the row before it, each IMG_WIDTH x 8. On each `acc` at column c: `lb1[c] <= lb0[c]` and `lb0[c] <= pix_in`.
- Window: three columns of {top, mid, bottom} = {`lb1[c]`, `lb0[c]`, `pix_in`}, shifted left on each `acc`. The newest column is driven combinationally from the buffer reads and `pix_in`; the older two columns come from registers.
- Tap mapping, taken from the window including the newest column: p2, p5, p8 are the newest column; p0, p3, p6 are the oldest; p1 and p7 are the middle column.
- `sob_*` taps are meaningful only in the cycle of `acc`.
- Output: on `acc` with `row >= 2` and `col >= 2`, `edge_out <= sob_result` and `edge_valid <= 1`. This result belongs to centre pixel (row-1, col-1).
- `edge_eol <= (col == IMG_WIDTH-1)`.
- `edge_valid` clears on `edge_ready` unless a new result is loaded in the same cycle.
- Each frame yields exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) results. Border pixels are never output.
- `busy` = FSM state is not IDLE.

## Timing
- Reset values:
  - FSM = IDLE; `row` = `col` = 0.
  - `edge_out` = 0, `edge_valid` = 0, `edge_eol` = 0, `frame_done` = 0, `busy` = 0.
  - `sob_threshold` = 0, window registers = 0.
  - `pix_ready` = 1.
  - Line buffer contents: don't-care.
- Latency: an edge bit is valid on the cycle after its triggering pixel is accepted.
- Throughput: one pixel per cycle while `edge_ready` = 1.
- `edge_valid`, `edge_out`, and `edge_eol` hold steady while `edge_valid & ~edge_ready`.
- Simultaneous `edge_ready` and `acc`: the old result is consumed and the new one is loaded in the same edge.
- `frame_done` asserts on the cycle after the final `acc` and lasts exactly one cycle. If that final pixel is also an interior pixel, `edge_valid` rises in the same cycle as `frame_done`.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously). The next frame requires an SOF.

## Configuration
- `SOBEL_EDGE_COUNT_EN` defined:
  - Adds output `edge_count` (16 bits). It counts results with `edge_out` = 1 in the current frame and saturates at 0xFFFF.
  - It clears on an accepted SOF and on reset.
  - It holds its value after `frame_done` until the next SOF.
- `SOBEL_EDGE_COUNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
All cases use IMG_WIDTH = 5 and IMG_HEIGHT = 4, so each frame produces 6 results.
- Zero frame: 20 pixels of 0x00, threshold 200 → six results, all `edge_out` = 0. `edge_eol` is set on the 3rd and 6th results; one `frame_done` pulse.
- Vertical step: columns 0-1 = 0x00, columns 2-4 = 0xFF, threshold 200 → results 1,1,0 per row (Gx = 1020, 1020, 0). With the macro defined, `edge_count` = 4.
- Backpressure: step frame with `edge_ready` toggled 1-0-0-1 → `pix_ready` low while output is held, no result lost or duplicated, same 1,1,0,1,1,0 sequence.
- Restart: SOF reasserted at pixel (2,3), then a full zero frame → counters restart, exactly 6 further results, one `frame_done`.
- Reset mid-frame: `rst_n` pulsed low at pixel (2,1) → `edge_valid`, `busy` = 0 immediately. Non-SOF pixels are then dropped with `pix_ready` = 1 until the next SOF.
- Threshold latch: step frame, `threshold_in` changed to 0xFF after the SOF → `sob_threshold` stays 200 for the whole frame.
